// File: rtl/mem16_bridge_pkg.sv
// Shared FSM state type and core write-enable encodings for mem16_bridge.
// MEM16_RMW_EN adds the RMW_WR state used by byte writes.
package RS5_pkg;

  localparam logic [3:0] WE_READ = 4'b0000;
  localparam logic [3:0] WE_WORD = 4'b1111;
  localparam logic [3:0] WE_HALF = 4'b0011;
  localparam logic [3:0] WE_BYTE = 4'b0001;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    RD_WAIT = 2'd1,
    WR_HI   = 2'd2
`ifdef MEM16_RMW_EN
    , RMW_WR = 2'd3
`endif
  } mem16_state_t;

endpackage

// File: rtl/mem16_bridge_if.sv
// Core-side request/response bus of mem16_bridge; master = core, slave = bridge.
interface mem16_bridge_if;
  logic        req_i;
  logic [3:0]  we_i;
  logic [31:0] addr_i;
  logic [31:0] data_i;
  logic        gnt_o;
  logic        busy_o;
  logic        rvalid_o;
  logic [31:0] rdata_o;
  logic        err_o;

  modport master (
    output req_i, we_i, addr_i, data_i,
    input  gnt_o, busy_o, rvalid_o, rdata_o, err_o
  );

  modport slave (
    input  req_i, we_i, addr_i, data_i,
    output gnt_o, busy_o, rvalid_o, rdata_o, err_o
  );
endinterface

// File: rtl/mem16_bridge.sv
// Bridges 32-bit core accesses onto a 16-bit-wide RAM (two halfword accesses per word).
// Define MEM16_RMW_EN to support byte writes via read-modify-write; otherwise they are rejected.
module mem16_bridge
  import RS5_pkg::*;
#(
  parameter  int MEM_WIDTH = 65536,
  localparam int AW        = $clog2(MEM_WIDTH)
) (
  input  logic             clk,
  input  logic             rst,
  mem16_bridge_if.slave    core,
  output logic             ram_en_o,
  output logic             ram_we_o,
  output logic [AW-1:0]    ram_addr_o,
  output logic [31:0]      ram_data_o,
  input  logic [31:0]      ram_data_a_i,
  input  logic [31:0]      ram_data_b_i
);

  mem16_state_t  state, state_nxt;
  logic [AW-1:0] idx, hold_idx;
  logic [15:0]   hold_data;
  logic          idle, bad_we, misaligned, reject, accept;
`ifdef MEM16_RMW_EN
  logic          hold_lane;
  logic [15:0]   merged;
`endif

  // Upper bits of the RAM read ports and address bits above the RAM are ignored.
  logic unused_bits;
  assign unused_bits = ^{ram_data_a_i[31:16], ram_data_b_i[31:16], core.addr_i[31:AW+1]};

  assign idx  = core.addr_i[AW:1];
  assign idle = (state == IDLE);

  always_comb begin
    bad_we     = 1'b1;
    misaligned = 1'b0;
    case (core.we_i)
      WE_READ: bad_we = 1'b0;
      WE_WORD, WE_HALF: begin
        bad_we     = 1'b0;
        misaligned = core.addr_i[0];
      end
`ifdef MEM16_RMW_EN
      WE_BYTE: bad_we = 1'b0;
`endif
      default: bad_we = 1'b1;
    endcase
  end

  assign reject        = bad_we | misaligned;
  assign core.gnt_o    = core.req_i & idle & ~rst;
  assign core.err_o    = core.gnt_o & reject;
  assign accept        = core.gnt_o & ~reject;
  assign core.busy_o   = ~idle;
  assign core.rvalid_o = (state == RD_WAIT);
  assign core.rdata_o  = core.rvalid_o ? {ram_data_b_i[15:0], ram_data_a_i[15:0]} : 32'h0;

`ifdef MEM16_RMW_EN
  assign merged = hold_lane ? {hold_data[7:0], ram_data_a_i[7:0]}
                            : {ram_data_a_i[15:8], hold_data[7:0]};
`endif

  always_comb begin
    // NOTE: every output gets a default first so no path can infer a latch.
    state_nxt  = state;
    ram_en_o   = 1'b0;
    ram_we_o   = 1'b0;
    ram_addr_o = '0;
    ram_data_o = 32'h0;
    case (state)
      IDLE: begin
        if (accept) begin
          ram_en_o   = 1'b1;
          ram_addr_o = idx;
          case (core.we_i)
            WE_WORD: begin
              ram_we_o   = 1'b1;
              ram_data_o = {16'h0, core.data_i[15:0]};
              state_nxt  = WR_HI;
            end
            WE_HALF: begin
              ram_we_o   = 1'b1;
              ram_data_o = {16'h0, core.data_i[15:0]};
            end
`ifdef MEM16_RMW_EN
            WE_BYTE: state_nxt = RMW_WR;
`endif
            default: state_nxt = RD_WAIT;  // only reads survive the reject decode
          endcase
        end
      end
      RD_WAIT: state_nxt = IDLE;
      WR_HI: begin
        ram_en_o   = 1'b1;
        ram_we_o   = 1'b1;
        ram_addr_o = hold_idx;
        ram_data_o = {16'h0, hold_data};
        state_nxt  = IDLE;
      end
`ifdef MEM16_RMW_EN
      RMW_WR: begin
        ram_en_o   = 1'b1;
        ram_we_o   = 1'b1;
        ram_addr_o = hold_idx;
        ram_data_o = {16'h0, merged};
        state_nxt  = IDLE;
      end
`endif
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    // NOTE: non-blocking for all state so every register samples pre-edge values.
    if (rst) begin
      state     <= IDLE;
      hold_idx  <= '0;
      hold_data <= 16'h0;
`ifdef MEM16_RMW_EN
      hold_lane <= 1'b0;
`endif
    end else begin
      state <= state_nxt;
      if (accept) begin
        if (core.we_i == WE_WORD) begin
          hold_idx  <= idx + 1'b1;
          hold_data <= core.data_i[31:16];
        end else begin
          hold_idx  <= idx;
          hold_data <= {8'h0, core.data_i[7:0]};
        end
`ifdef MEM16_RMW_EN
        hold_lane <= core.addr_i[0];
`endif
      end
    end
  end

endmodule

// File: tb/tb_mem16_bridge.sv
// Self-checking bench for mem16_bridge: directed table, hand-written corner sequences,
// and random traffic against a halfword-array reference model. Follows MEM16_RMW_EN.
module tb_mem16_bridge;
  localparam int MW = 1024;
  localparam int AW = $clog2(MW);
`ifdef MEM16_RMW_EN
  localparam bit RMW = 1'b1;
`else
  localparam bit RMW = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  mem16_bridge_if bus ();

  logic          ram_en, ram_we;
  logic [AW-1:0] ram_addr;
  logic [31:0]   ram_wdata, ram_a, ram_b;

  mem16_bridge #(.MEM_WIDTH(MW)) dut (
    .clk          (clk),
    .rst          (rst),
    .core         (bus),
    .ram_en_o     (ram_en),
    .ram_we_o     (ram_we),
    .ram_addr_o   (ram_addr),
    .ram_data_o   (ram_wdata),
    .ram_data_a_i (ram_a),
    .ram_data_b_i (ram_b)
  );

  // Bench-side 16-bit RAM with two read ports (idx and idx+1), one-cycle read latency.
  logic [15:0] ram_mem [MW] = '{default: 16'h0};
  int unsigned acc_cnt = 0;
  logic [31:0] wlog [$];

  always @(posedge clk) begin
    if (ram_en) begin
      acc_cnt <= acc_cnt + 1;
      if (ram_we) begin
        ram_mem[ram_addr] <= ram_wdata[15:0];
        wlog.push_back({16'(ram_addr), ram_wdata[15:0]});
      end else begin
        ram_a <= {16'h0, ram_mem[ram_addr]};
        ram_b <= {16'h0, ram_mem[AW'(ram_addr + 1'b1)]};
      end
    end
  end

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, got, exp);
    end
  endtask

  // Reference model: plain halfword array updated from the access rules.
  logic [15:0] ref_mem [MW] = '{default: 16'h0};

  function automatic int ref_idx(input logic [31:0] addr);
    return int'((addr >> 1) % MW);
  endfunction

  function automatic bit ref_err(input logic [3:0] we, input logic [31:0] addr);
    case (we)
      4'b0000:          return 1'b0;
      4'b1111, 4'b0011: return addr[0];
      4'b0001:          return !RMW;
      default:          return 1'b1;
    endcase
  endfunction

  function automatic logic [31:0] ref_read(input logic [31:0] addr);
    int i = ref_idx(addr);
    return {ref_mem[(i + 1) % MW], ref_mem[i]};
  endfunction

  task automatic ref_apply(input logic [3:0] we, input logic [31:0] addr, input logic [31:0] data);
    int i = ref_idx(addr);
    if (!ref_err(we, addr)) begin
      case (we)
        4'b1111: begin
          ref_mem[i]            = data[15:0];
          ref_mem[(i + 1) % MW] = data[31:16];
        end
        4'b0011: ref_mem[i] = data[15:0];
        4'b0001: if (addr[0]) ref_mem[i][15:8] = data[7:0];
                 else         ref_mem[i][7:0]  = data[7:0];
        default: ;
      endcase
    end
  endtask

  // One core transaction: waits (bounded) for grant, then observes the two following cycles.
  task automatic do_op(input logic [3:0] we, input logic [31:0] addr, input logic [31:0] data,
                       output logic granted, output logic e, output logic b1, output logic b2,
                       output logic rv, output logic [31:0] rd, output int acc);
    int a0;
    int waitc = 0;
    @(negedge clk);
    bus.req_i = 1'b1; bus.we_i = we; bus.addr_i = addr; bus.data_i = data;
    #1;
    a0 = int'(acc_cnt);
    while (!bus.gnt_o && waitc < 20) begin
      @(negedge clk); #1;
      waitc++;
    end
    granted = bus.gnt_o;
    e       = bus.err_o;
    @(posedge clk); #1;
    bus.req_i = 1'b0; bus.we_i = 4'h0; bus.addr_i = 32'h0; bus.data_i = 32'h0;
    @(negedge clk);
    b1 = bus.busy_o; rv = bus.rvalid_o; rd = bus.rdata_o;
    @(negedge clk);
    b2  = bus.busy_o;
    acc = int'(acc_cnt) - a0;
  endtask

  task automatic run_op(input string name, input logic [3:0] we, input logic [31:0] addr,
                        input logic [31:0] data, input logic exp_err, input logic [31:0] exp_rd);
    logic granted, e, b1, b2, rv;
    logic [31:0] rd;
    int acc, exp_acc;
    logic exp_busy, exp_rv;
    do_op(we, addr, data, granted, e, b1, b2, rv, rd, acc);
    exp_rv   = !exp_err && (we == 4'b0000);
    exp_busy = !exp_err && (we != 4'b0011);
    exp_acc  = exp_err ? 0 : ((we == 4'b1111 || we == 4'b0001) ? 2 : 1);
    check($sformatf("%s.gnt", name),    granted, 1);
    check($sformatf("%s.err", name),    e, exp_err);
    check($sformatf("%s.busy", name),   b1, exp_busy);
    check($sformatf("%s.idle", name),   b2, 0);
    check($sformatf("%s.rvalid", name), rv, exp_rv);
    check($sformatf("%s.rdata", name),  rd, exp_rv ? exp_rd : 32'h0);
    check($sformatf("%s.ram_acc", name), acc, exp_acc);
  endtask

  task automatic check_quiet(input string name);
    check($sformatf("%s.gnt", name),    bus.gnt_o, 0);
    check($sformatf("%s.busy", name),   bus.busy_o, 0);
    check($sformatf("%s.rvalid", name), bus.rvalid_o, 0);
    check($sformatf("%s.rdata", name),  bus.rdata_o, 0);
    check($sformatf("%s.err", name),    bus.err_o, 0);
    check($sformatf("%s.ram_en", name), ram_en, 0);
    check($sformatf("%s.ram_we", name), ram_we, 0);
    check($sformatf("%s.ram_addr", name), 32'(ram_addr), 0);
    check($sformatf("%s.ram_data", name), ram_wdata, 0);
  endtask

  typedef struct {
    logic [3:0]  we;
    logic [31:0] addr;
    logic [31:0] data;
    logic        err;
    logic [31:0] rdata;
  } vec_t;

  vec_t vecs [14];

  initial begin
    #1000000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1);
  end

  initial begin
    logic [3:0]  we;
    logic [31:0] addr, data, base;
    int nmis;

    bus.req_i = 1'b0; bus.we_i = 4'h0; bus.addr_i = 32'h0; bus.data_i = 32'h0;

    // Reset state, with a request pending that must not be granted.
    repeat (2) @(negedge clk);
    bus.req_i = 1'b1; #1;
    check_quiet("reset");
    bus.req_i = 1'b0;
    @(negedge clk);
    rst = 1'b0;

    // Word write splits into two consecutive halfword writes.
    wlog.delete();
    run_op("word_dead", 4'hF, 32'h10, 32'hDEADBEEF, 1'b0, 32'h0);
    ref_apply(4'hF, 32'h10, 32'hDEADBEEF);
    check("word_dead.nwrites", wlog.size(), 2);
    if (wlog.size() == 2) begin
      check("word_dead.w0", wlog[0], 32'h0008_BEEF);
      check("word_dead.w1", wlog[1], 32'h0009_DEAD);
    end

    vecs[0]  = '{4'h0, 32'h10,            32'h0,        1'b0, 32'hDEADBEEF};
    vecs[1]  = '{4'h1, 32'h11,            32'h55,       !RMW, 32'h0};
    vecs[2]  = '{4'h0, 32'h10,            32'h0,        1'b0, RMW ? 32'hDEAD55EF : 32'hDEADBEEF};
    vecs[3]  = '{4'h3, 32'h3,             32'h1234,     1'b1, 32'h0};
    vecs[4]  = '{4'h0, 32'h2,             32'h0,        1'b0, 32'h0};
    vecs[5]  = '{4'hF, 32'(2 * (MW - 1)), 32'hCAFEF00D, 1'b0, 32'h0};
    vecs[6]  = '{4'h0, 32'(2 * (MW - 1)), 32'h0,        1'b0, 32'hCAFEF00D};
    vecs[7]  = '{4'h0, 32'h0,             32'h0,        1'b0, 32'h0000CAFE};
    vecs[8]  = '{4'h5, 32'h20,            32'h77,       1'b1, 32'h0};
    vecs[9]  = '{4'h3, 32'h20,            32'hFFFFA5A5, 1'b0, 32'h0};
    vecs[10] = '{4'h0, 32'h21,            32'h0,        1'b0, 32'h0000A5A5};
    vecs[11] = '{4'hF, 32'h11,            32'h11112222, 1'b1, 32'h0};
    vecs[12] = '{4'h1, 32'h20,            32'h3C,       !RMW, 32'h0};
    vecs[13] = '{4'h0, 32'h20,            32'h0,        1'b0, RMW ? 32'h0000A53C : 32'h0000A5A5};

    for (int i = 0; i < 14; i++) begin
      run_op($sformatf("vec%0d", i), vecs[i].we, vecs[i].addr, vecs[i].data, vecs[i].err, vecs[i].rdata);
      ref_apply(vecs[i].we, vecs[i].addr, vecs[i].data);
    end

    // Reset while the high halfword write is pending aborts it.
    @(negedge clk);
    bus.req_i = 1'b1; bus.we_i = 4'hF; bus.addr_i = 32'h60; bus.data_i = 32'h12345678;
    #1;
    check("rst_mid.gnt", bus.gnt_o, 1);
    @(posedge clk); #1;
    bus.we_i = 4'h0;
    check("rst_mid.in_wr_hi", bus.busy_o, 1);
    nmis = int'(acc_cnt);
    rst = 1'b1; #1;
    check_quiet("rst_mid");
    repeat (2) @(negedge clk);
    check("rst_mid.no_write", int'(acc_cnt) - nmis, 0);
    check("rst_mid.hi_kept", ram_mem[8'h31], 16'h0);
    bus.req_i = 1'b0;
    rst = 1'b0;
    ref_mem[ref_idx(32'h60)] = 16'h5678;
    run_op("rst_mid.after", 4'h0, 32'h60, 32'h0, 1'b0, ref_read(32'h60));

    // Random traffic against the reference model.
    for (int n = 0; n < 300; n++) begin
      case ($urandom_range(0, 9))
        0, 1, 2: we = 4'h0;
        3, 4:    we = 4'hF;
        5, 6:    we = 4'h3;
        7, 8:    we = 4'h1;
        default: we = 4'($urandom_range(0, 15));
      endcase
      base = ($urandom_range(0, 3) == 0) ? 32'(2 * MW - 4) : 32'h0;
      addr = ($urandom() & 32'hFFFF_F000) | (base + 32'($urandom_range(0, 63)));
      data = $urandom();
      run_op($sformatf("rnd%0d", n), we, addr, data, ref_err(we, addr), ref_read(addr));
      ref_apply(we, addr, data);
    end

    nmis = 0;
    for (int i = 0; i < MW; i++)
      if (ram_mem[i] !== ref_mem[i]) nmis++;
    check("final_mem_diffs", nmis, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
